bus_regfile_6502: RTL

Parametrised 6502-bus peripheral register file: the next generation of our 6502 interface block. It samples the external 1 MHz bus clock, chip select, register select, write enable and data bus into the internal 50 MHz domain. It commits each bus cycle at the detected falling edge of phi2 and supports read-back. It drives an auto-incrementing port into a synchronous RAM, an LED register and general scratch registers.

---
 rtl/bus_regfile_6502.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/bus_regfile_6502.sv
`default_nettype none
// ============================================================================
// Module   : bus_regfile_6502
// Brief    : 6502-bus peripheral register file (pointer/RAM port, LED, CTRL,
//            scratch) sampled from phi2 into the clk domain.
//            Optional interrupt logic under macro BUS_REGFILE_IRQ_EN.
// Revision : 1.0 - initial release
// ============================================================================
module bus_regfile_6502 #(
  parameter int DATA_W = 8,
  parameter int RS_W   = 4,
  parameter int RAM_AW = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clk_ext1,
  input  logic              cs,
  input  logic [RS_W-1:0]   rs,
  input  logic              wren,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_oe,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] led
`ifdef BUS_REGFILE_IRQ_EN
  ,
  output logic              irq_n
`endif
);

  localparam int              NREG      = 2**RS_W;
  localparam logic [RS_W-1:0] RS_PTR_LO = RS_W'(0);
  localparam logic [RS_W-1:0] RS_PTR_HI = RS_W'(1);
  localparam logic [RS_W-1:0] RS_DATA   = RS_W'(2);
  localparam logic [RS_W-1:0] RS_CTRL   = RS_W'(3);
  localparam logic [RS_W-1:0] RS_LED    = RS_W'(4);
  localparam logic [RS_W-1:0] RS_SCR0   = RS_W'(5);

  logic              ext_m_q, phi2_s_q, cs_m_q, cs_s_q, phi2_d_q;
  logic [1:0]        settle_q;
  logic              armed_q;
  logic              sel_q;
  logic [RS_W-1:0]   cap_rs_q;
  logic              cap_wren_q;
  logic [DATA_W-1:0] cap_data_q;
  logic [RAM_AW-1:0] ptr_q, ptr_d;
  logic              inc_q;
  logic              ainc_q;
  logic [DATA_W-1:0] led_q, data_out_q, ram_wdata_q, rd_mux;
  logic              ram_we_q;
  logic [DATA_W-1:0] scratch_q [NREG];
  logic              commit, wr_commit;
`ifdef BUS_REGFILE_IRQ_EN
  logic              ie_q, if_q, irq_n_q, wrap;
`endif

  assign commit    = phi2_d_q & ~phi2_s_q & sel_q;
  assign wr_commit = commit & ~cap_wren_q;

  // Synchronised chain is all-zero after reset, so it cannot be trusted until
  // it has refilled; a cycle is only captured after a genuine low phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_m_q    <= 1'b0;
      phi2_s_q   <= 1'b0;
      cs_m_q     <= 1'b0;
      cs_s_q     <= 1'b0;
      phi2_d_q   <= 1'b0;
      settle_q   <= 2'b00;
      armed_q    <= 1'b0;
      sel_q      <= 1'b0;
      cap_rs_q   <= '0;
      cap_wren_q <= 1'b1;
      cap_data_q <= '0;
    end else begin
      ext_m_q  <= clk_ext1;
      phi2_s_q <= ext_m_q;
      cs_m_q   <= cs;
      cs_s_q   <= cs_m_q;
      phi2_d_q <= phi2_s_q;
      settle_q <= {settle_q[0], 1'b1};
      if (settle_q[1] && !phi2_s_q) armed_q <= 1'b1;
      if (armed_q && phi2_s_q && !cs_s_q) begin
        cap_rs_q   <= rs;
        cap_wren_q <= wren;
        cap_data_q <= data_in;
        sel_q      <= 1'b1;
      end else if (commit) begin
        sel_q <= 1'b0;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (inc_q) ptr_d = ptr_q + RAM_AW'(1);
    if (wr_commit && cap_rs_q == RS_PTR_LO) begin
      for (int i = 0; i < RAM_AW; i++)
        if (i < 8) ptr_d[i] = cap_data_q[i % 8];
    end
    if (wr_commit && cap_rs_q == RS_PTR_HI) begin
      for (int i = 0; i < RAM_AW; i++)
        if (i >= 8) ptr_d[i] = cap_data_q[i % 8];
    end
  end

`ifdef BUS_REGFILE_IRQ_EN
  assign wrap = inc_q & (&ptr_q);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      inc_q       <= 1'b0;
      ainc_q      <= 1'b1;
      led_q       <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
      data_out_q  <= '0;
      for (int i = 0; i < NREG; i++) scratch_q[i] <= '0;
`ifdef BUS_REGFILE_IRQ_EN
      ie_q        <= 1'b0;
      if_q        <= 1'b0;
      irq_n_q     <= 1'b1;
`endif
    end else begin
      ptr_q      <= ptr_d;
      ram_we_q   <= wr_commit && (cap_rs_q == RS_DATA);
      inc_q      <= commit && (cap_rs_q == RS_DATA) && ainc_q;
      data_out_q <= rd_mux;
      if (wr_commit) begin
        case (cap_rs_q)
          RS_DATA: ram_wdata_q <= cap_data_q;
          RS_CTRL: begin
            ainc_q <= cap_data_q[0];
`ifdef BUS_REGFILE_IRQ_EN
            ie_q   <= cap_data_q[1];
`endif
          end
          RS_LED:  led_q <= cap_data_q;
          default: if (cap_rs_q >= RS_SCR0) scratch_q[cap_rs_q] <= cap_data_q;
        endcase
      end
`ifdef BUS_REGFILE_IRQ_EN
      // A wrap beats a simultaneous write-1-to-clear.
      if (wrap)
        if_q <= 1'b1;
      else if (wr_commit && cap_rs_q == RS_CTRL && cap_data_q[7])
        if_q <= 1'b0;
      irq_n_q <= ~(if_q & ie_q);
`endif
    end
  end

  always_comb begin
    rd_mux = '0;
    case (rs)
      RS_PTR_LO: begin
        for (int i = 0; i < 8; i++)
          if (i < RAM_AW) rd_mux[i] = ptr_q[i % RAM_AW];
      end
      RS_PTR_HI: begin
        for (int i = 0; i < 8; i++)
          if (i + 8 < RAM_AW) rd_mux[i] = ptr_q[(i + 8) % RAM_AW];
      end
      RS_DATA: rd_mux = ram_rdata;
      RS_CTRL: begin
        rd_mux[0] = ainc_q;
`ifdef BUS_REGFILE_IRQ_EN
        rd_mux[1] = ie_q;
        rd_mux[7] = if_q;
`endif
      end
      RS_LED:  rd_mux = led_q;
      default: rd_mux = scratch_q[rs];
    endcase
  end

  assign data_out  = data_out_q;
  assign data_oe   = clk_ext1 & ~cs & wren;
  assign ram_addr  = ptr_q;
  assign ram_wdata = ram_wdata_q;
  assign ram_we    = ram_we_q;
  assign led       = led_q;
`ifdef BUS_REGFILE_IRQ_EN
  assign irq_n     = irq_n_q;
`endif

endmodule
`default_nettype wire
